// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, field positions, exception codes.
package cp0_pkg;

    // Coprocessor-0 register numbers as seen on A1/A2
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Field bit positions inside SR and Cause
    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LO      = 10;
    localparam int SR_IM_HI      = 15;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_IP_LO   = 10;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_BD_BIT  = 31;

    // Exception codes latched into Cause.ExcCode
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Implemented Status fields
    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    // Place the implemented Status fields at their architectural bit positions
    function automatic logic [31:0] sr_word(input sr_t s);
        logic [31:0] w;
        w = '0;
        w[SR_IM_HI:SR_IM_LO] = s.im;
        w[SR_EXL_BIT]        = s.exl;
        w[SR_IE_BIT]         = s.ie;
        return w;
    endfunction

endpackage

// File: rtl/cp0_if.sv
// CP0 pipeline-facing bus: register access, victim info, interrupt lines.
interface cp0_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [29:0] PC;
    logic        BD;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [29:0] EPC;
    logic [31:0] DOut;

    // Pipeline side
    modport master (
        output A1, A2, DIn, WE, PC, BD, ExcCode, HWInt, EXLClr,
        input  IntReq, EPC, DOut
    );

    // Coprocessor side
    modport slave (
        input  A1, A2, DIn, WE, PC, BD, ExcCode, HWInt, EXLClr,
        output IntReq, EPC, DOut
    );
endinterface

// File: rtl/cp0_req_gen.sv
// Request generation: decides whether this cycle takes an interrupt or
// exception and which code to record. Build option CP0_EXC_EN enables
// synchronous exceptions; without it only interrupts are taken.
module cp0_req_gen
    import cp0_pkg::*;
(
    input  logic [5:0] hwint,
    input  sr_t        sr,
    input  logic [4:0] exccode,
    output logic       int_pend,
    output logic       exc_pend,
    output logic       int_req,
    output logic [4:0] exc_lat
);

    logic [5:0] masked;

    // Per-line interrupt masking by SR.IM
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_mask
            assign masked[gi] = hwint[gi] & sr.im[gi];
        end
    endgenerate

    // Live interrupt lines feed straight through so the request has no latency
    assign int_pend = (|masked) & sr.ie & ~sr.exl;

`ifdef CP0_EXC_EN
    assign exc_pend = (exccode != EXC_INT) & ~sr.exl;
    // Interrupt wins over a coincident exception
    assign exc_lat  = int_pend ? EXC_INT : exccode;
`else
    logic unused_exccode;
    assign unused_exccode = ^exccode;
    assign exc_pend = 1'b0;
    assign exc_lat  = EXC_INT;
`endif

    assign int_req = int_pend | exc_pend;

endmodule

// File: rtl/cp0.sv
// CP0 top: SR/Cause/EPC registers, capture on request, eret, mtc0 writes and
// the combinational read mux. Build option CP0_EXC_EN (see cp0_req_gen)
// lets ExcCode raise requests.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h0000_2017
) (
    input  logic clk,
    input  logic reset,
    cp0_if.slave bus
);

    sr_t         sr_reg;
    logic        bd_reg;
    logic [5:0]  ip_reg;
    logic [4:0]  exc_reg;
    logic [29:0] epc_reg;

    logic        int_pend;
    logic        exc_pend;
    logic        int_req;
    logic [4:0]  exc_lat;
    logic [31:0] cause_word;

    cp0_req_gen u_req_gen (
        .hwint    (bus.HWInt),
        .sr       (sr_reg),
        .exccode  (bus.ExcCode),
        .int_pend (int_pend),
        .exc_pend (exc_pend),
        .int_req  (int_req),
        .exc_lat  (exc_lat)
    );

    // The pending flags are folded into int_req; kept as ports for visibility
    logic unused_pend;
    assign unused_pend = int_pend ^ exc_pend;

    // State update: request capture beats eret, which beats mtc0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_reg  <= '0;
            bd_reg  <= 1'b0;
            ip_reg  <= '0;
            exc_reg <= '0;
            epc_reg <= '0;
        end else begin
            ip_reg <= bus.HWInt;
            if (int_req) begin
                sr_reg.exl <= 1'b1;
                bd_reg     <= bus.BD;
                epc_reg    <= bus.BD ? (bus.PC - 30'd1) : bus.PC;
                exc_reg    <= exc_lat;
            end else if (bus.EXLClr) begin
                sr_reg.exl <= 1'b0;
            end else if (bus.WE) begin
                case (bus.A2)
                    REG_SR: begin
                        sr_reg.im  <= bus.DIn[SR_IM_HI:SR_IM_LO];
                        sr_reg.exl <= bus.DIn[SR_EXL_BIT];
                        sr_reg.ie  <= bus.DIn[SR_IE_BIT];
                    end
                    REG_EPC: epc_reg <= bus.DIn[31:2];
                    default: ;
                endcase
            end
        end
    end

    // Cause layout: BD at 31, IP at 15:10, ExcCode at 6:2, rest zero
    assign cause_word = {bd_reg, 15'b0, ip_reg, 3'b0, exc_reg, 2'b0};

    // Combinational read port; reads see current register contents only
    always_comb begin
        bus.DOut = '0;
        case (bus.A1)
            REG_SR:    bus.DOut = sr_word(sr_reg);
            REG_CAUSE: bus.DOut = cause_word;
            REG_EPC:   bus.DOut = {epc_reg, 2'b00};
            REG_PRID:  bus.DOut = PRID_VAL;
            default:   bus.DOut = '0;
        endcase
    end

    assign bus.IntReq = int_req;
    assign bus.EPC    = epc_reg;

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: reset, interrupt capture, delay-slot EPC, eret,
// write ordering, Cause.IP sampling, masking, exceptions and async reset.
module tb_cp0;
    localparam logic [31:0] PRID = 32'h0000_2017;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    cp0_if bus ();

    cp0 #(.PRID_VAL(PRID)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = '0; bus.WE = 1'b0;
        bus.PC = '0; bus.BD = 1'b0; bus.ExcCode = '0; bus.HWInt = '0; bus.EXLClr = 1'b0;
        #1;
        bus.A1 = 5'd12; #1;
        n_vec++; if (bus.DOut !== 32'h0) begin n_bad++; $display("FAIL reset_sr got %h want %h", bus.DOut, 32'h0); end
        bus.A1 = 5'd13; #1;
        n_vec++; if (bus.DOut !== 32'h0) begin n_bad++; $display("FAIL reset_cause got %h want %h", bus.DOut, 32'h0); end
        bus.A1 = 5'd14; #1;
        n_vec++; if (bus.DOut !== 32'h0) begin n_bad++; $display("FAIL reset_epc got %h want %h", bus.DOut, 32'h0); end
        bus.A1 = 5'd15; #1;
        n_vec++; if (bus.DOut !== PRID) begin n_bad++; $display("FAIL reset_prid got %h want %h", bus.DOut, PRID); end
        n_vec++; if (bus.IntReq !== 1'b0) begin n_bad++; $display("FAIL reset_intreq got %b want 0", bus.IntReq); end
        tick(); tick();
        reset = 1'b0;
        tick();
        $display("reset: done");
    endtask

    task automatic test_int_capture();
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
        tick();
        bus.WE = 1'b0;
        bus.A1 = 5'd12; #1;
        n_vec++; if (bus.DOut !== 32'h0000_0401) begin n_bad++; $display("FAIL sr_write got %h want %h", bus.DOut, 32'h401); end
        bus.HWInt = 6'b000001; bus.PC = 30'h0C00; bus.BD = 1'b0; #1;
        n_vec++; if (bus.IntReq !== 1'b1) begin n_bad++; $display("FAIL int_same_cycle got %b want 1", bus.IntReq); end
        tick();
        n_vec++; if (bus.EPC !== 30'h0C00) begin n_bad++; $display("FAIL int_epc got %h want %h", bus.EPC, 30'h0C00); end
        n_vec++; if (bus.IntReq !== 1'b0) begin n_bad++; $display("FAIL int_exl_blocks got %b want 0", bus.IntReq); end
        bus.A1 = 5'd12; #1;
        n_vec++; if (bus.DOut !== 32'h0000_0403) begin n_bad++; $display("FAIL int_sr_exl got %h want %h", bus.DOut, 32'h403); end
        bus.A1 = 5'd13; #1;
        n_vec++; if (bus.DOut !== 32'h0000_0400) begin n_bad++; $display("FAIL int_cause got %h want %h", bus.DOut, 32'h400); end
        bus.A1 = 5'd14; #1;
        n_vec++; if (bus.DOut !== 32'h0000_3000) begin n_bad++; $display("FAIL int_epc_read got %h want %h", bus.DOut, 32'h3000); end
        $display("int_capture: EPC=%h", bus.EPC);
    endtask

    task automatic test_eret();
        bus.EXLClr = 1'b1; #1;
        n_vec++; if (bus.IntReq !== 1'b0) begin n_bad++; $display("FAIL eret_before got %b want 0", bus.IntReq); end
        tick();
        bus.EXLClr = 1'b0;
        n_vec++; if (bus.IntReq !== 1'b1) begin n_bad++; $display("FAIL eret_rerequest got %b want 1", bus.IntReq); end
        bus.A1 = 5'd12; #1;
        n_vec++; if (bus.DOut !== 32'h0000_0401) begin n_bad++; $display("FAIL eret_sr got %h want %h", bus.DOut, 32'h401); end
        $display("eret: IntReq=%b", bus.IntReq);
    endtask

    task automatic test_bd_capture();
        bus.BD = 1'b1; bus.PC = 30'h0C01;
        tick();
        bus.BD = 1'b0;
        n_vec++; if (bus.EPC !== 30'h0C00) begin n_bad++; $display("FAIL bd_epc got %h want %h", bus.EPC, 30'h0C00); end
        bus.A1 = 5'd13; #1;
        n_vec++; if (bus.DOut !== 32'h8000_0400) begin n_bad++; $display("FAIL bd_cause got %h want %h", bus.DOut, 32'h8000_0400); end
        $display("bd_capture: EPC=%h", bus.EPC);
    endtask

    task automatic test_we_drop();
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;
        bus.PC = 30'h0123; bus.BD = 1'b0;
        bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3008;
        tick();
        bus.WE = 1'b0;
        n_vec++; if (bus.EPC !== 30'h0123) begin n_bad++; $display("FAIL we_dropped_epc got %h want %h", bus.EPC, 30'h0123); end
        bus.A1 = 5'd15; #1;
        n_vec++; if (bus.DOut !== PRID) begin n_bad++; $display("FAIL prid got %h want %h", bus.DOut, PRID); end
        bus.HWInt = 6'b0;
        bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3008;
        tick();
        bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
        tick();
        bus.A2 = 5'd15;
        tick();
        bus.WE = 1'b0;
        n_vec++; if (bus.EPC !== 30'h0C02) begin n_bad++; $display("FAIL epc_write got %h want %h", bus.EPC, 30'h0C02); end
        bus.A1 = 5'd13; #1;
        n_vec++; if (bus.DOut !== 32'h0) begin n_bad++; $display("FAIL cause_write_ignored got %h want %h", bus.DOut, 32'h0); end
        bus.A1 = 5'd15; #1;
        n_vec++; if (bus.DOut !== PRID) begin n_bad++; $display("FAIL prid_write_ignored got %h want %h", bus.DOut, PRID); end
        $display("we_drop: EPC=%h", bus.EPC);
    endtask

    task automatic test_ip_sample();
        bus.HWInt = 6'b100010;
        tick();
        bus.A1 = 5'd13; #1;
        n_vec++; if (bus.DOut !== 32'h0000_8800) begin n_bad++; $display("FAIL ip_sample got %h want %h", bus.DOut, 32'h8800); end
        n_vec++; if (bus.IntReq !== 1'b0) begin n_bad++; $display("FAIL ip_no_nest got %b want 0", bus.IntReq); end
        $display("ip_sample: Cause=%h", bus.DOut);
    endtask

    task automatic test_mask();
        bus.HWInt = 6'b000010;
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;
        n_vec++; if (bus.IntReq !== 1'b0) begin n_bad++; $display("FAIL im_masked got %b want 0", bus.IntReq); end
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0400;
        tick();
        bus.WE = 1'b0;
        bus.HWInt = 6'b000001; #1;
        n_vec++; if (bus.IntReq !== 1'b0) begin n_bad++; $display("FAIL ie_masked got %b want 0", bus.IntReq); end
        bus.HWInt = 6'b0;
        $display("mask: IntReq=%b", bus.IntReq);
    endtask

    task automatic test_exc();
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0;
        tick();
        bus.WE = 1'b0;
        bus.ExcCode = 5'd12; bus.PC = 30'h0040; bus.BD = 1'b0; #1;
`ifdef CP0_EXC_EN
        n_vec++; if (bus.IntReq !== 1'b1) begin n_bad++; $display("FAIL exc_req got %b want 1", bus.IntReq); end
`else
        n_vec++; if (bus.IntReq !== 1'b0) begin n_bad++; $display("FAIL exc_req got %b want 0", bus.IntReq); end
`endif
        tick();
        bus.ExcCode = 5'd0;
        bus.A1 = 5'd13; #1;
`ifdef CP0_EXC_EN
        n_vec++; if (bus.DOut !== 32'h0000_0030) begin n_bad++; $display("FAIL exc_cause got %h want %h", bus.DOut, 32'h30); end
        n_vec++; if (bus.EPC !== 30'h0040) begin n_bad++; $display("FAIL exc_epc got %h want %h", bus.EPC, 30'h0040); end
`else
        n_vec++; if (bus.DOut !== 32'h0) begin n_bad++; $display("FAIL exc_cause got %h want %h", bus.DOut, 32'h0); end
        n_vec++; if (bus.EPC !== 30'h0C02) begin n_bad++; $display("FAIL exc_epc got %h want %h", bus.EPC, 30'h0C02); end
`endif
        bus.ExcCode = 5'd4; #1;
        n_vec++; if (bus.IntReq !== 1'b0) begin n_bad++; $display("FAIL exc_blocked got %b want 0", bus.IntReq); end
        bus.ExcCode = 5'd0;
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
        tick();
        bus.WE = 1'b0;
        bus.HWInt = 6'b000001; bus.ExcCode = 5'd5; bus.PC = 30'h0050;
        tick();
        bus.HWInt = 6'b0; bus.ExcCode = 5'd0;
        n_vec++; if (bus.EPC !== 30'h0050) begin n_bad++; $display("FAIL prio_epc got %h want %h", bus.EPC, 30'h0050); end
        bus.A1 = 5'd13; #1;
        n_vec++; if (bus.DOut !== 32'h0000_0400) begin n_bad++; $display("FAIL prio_cause got %h want %h", bus.DOut, 32'h400); end
        $display("exc: Cause=%h EPC=%h", bus.DOut, bus.EPC);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        reset = 1'b1;
        #1;
        bus.A1 = 5'd12; #1;
        n_vec++; if (bus.DOut !== 32'h0) begin n_bad++; $display("FAIL async_sr got %h want %h", bus.DOut, 32'h0); end
        bus.A1 = 5'd13; #1;
        n_vec++; if (bus.DOut !== 32'h0) begin n_bad++; $display("FAIL async_cause got %h want %h", bus.DOut, 32'h0); end
        n_vec++; if (bus.EPC !== 30'h0) begin n_bad++; $display("FAIL async_epc got %h want %h", bus.EPC, 30'h0); end
        bus.HWInt = 6'b000001; bus.PC = 30'h0777;
        tick();
        n_vec++; if (bus.EPC !== 30'h0) begin n_bad++; $display("FAIL held_epc got %h want %h", bus.EPC, 30'h0); end
        bus.A1 = 5'd12; #1;
        n_vec++; if (bus.DOut !== 32'h0) begin n_bad++; $display("FAIL held_sr got %h want %h", bus.DOut, 32'h0); end
        n_vec++; if (bus.IntReq !== 1'b0) begin n_bad++; $display("FAIL held_intreq got %b want 0", bus.IntReq); end
        @(negedge clk);
        reset = 1'b0;
        bus.HWInt = 6'b0;
        #1;
        $display("reset_mid: done");
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_int_capture();
        test_eret();
        test_bd_capture();
        test_we_drop();
        test_ip_sample();
        test_mask();
        test_exc();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 Parameter PRID_VAL, default 32'h0000_2017, value returned on reads of PRId (reg 15).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 A1  input  5  combinational read register number.
REQ-005 A2  input  5  write register number.
REQ-006 DIn  input  32  write data (mtc0).
REQ-007 WE  input  1  write enable (mtc0).
REQ-008 PC  input  30  word address [31:2] of the victim instruction.
REQ-009 BD  input  1  victim instruction is in a branch delay slot.
REQ-010 ExcCode  input  5  synchronous exception code; 0 = none.
REQ-011 HWInt  input  6  device interrupt lines, bit 0 = timer 0, bit 1 = timer 1, from the bridge.
REQ-012 EXLClr  input  1  eret executed.
REQ-013 IntReq  output  1  exception/interrupt request to the pipeline flush and PC select logic.
REQ-014 EPC  output  30  EPC[31:2] for eret target.
REQ-015 DOut  output  32  read data for A1.

Function
REQ-016 State SHALL be SR.IM[15:10], SR.EXL[1], SR.IE[0], Cause.BD[31], Cause.IP[15:10], Cause.ExcCode[6:2], EPC[31:2]; all other bits read 0.
REQ-017 Cause.IP SHALL sample HWInt every cycle, independent of EXL.
REQ-018 IntPend = |(HWInt & SR.IM) & SR.IE & !SR.EXL, combinational from live HWInt (zero latency).
REQ-019 ExcPend = (ExcCode != 0) & !SR.EXL; IntReq = IntPend | ExcPend.
REQ-020 On an edge with IntReq=1: EXL<=1; Cause.BD<=BD; EPC<=BD ? PC-1 : PC (word units, 30-bit wrap); Cause.ExcCode<=IntPend ? 0 : ExcCode (interrupt has priority over exception).
REQ-021 Else if EXLClr=1: EXL<=0; all other state unchanged.
REQ-022 Else if WE=1: A2=12 loads IM, EXL, IE from DIn; A2=14 loads EPC<=DIn[31:2]; A2=13, 15 and others ignored.
REQ-023 Priority per edge: reset > IntReq > EXLClr > WE; a WE coinciding with IntReq is dropped.
REQ-024 DOut combinational: 12 -> SR, 13 -> Cause, 14 -> {EPC,2'b00}, 15 -> PRID_VAL, else 0; no write-through bypass.
REQ-025 IntReq SHALL be 0 whenever EXL=1 (no nesting).

Reset
REQ-026 Reset clears SR, Cause, EPC to 0 immediately; IntReq=0, DOut follows A1 with zeroed state.
REQ-027 Reset asserted mid-capture SHALL win; no partial EPC/EXL update.

Configuration
REQ-028 CP0_EXC_EN defined: ExcCode participates per REQ-019/020.
REQ-029 CP0_EXC_EN undefined: ExcCode ignored, ExcPend=0, Cause.ExcCode always written 0; interrupts only.

Structure
REQ-030 Package cp0_pkg SHALL hold register numbers (12-15), field bit positions, and ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
REQ-031 One sub-module cp0_req_gen SHALL compute IntPend, ExcPend, IntReq and the ExcCode to latch; cp0 holds registers and read mux.

Verification
REQ-032 Write SR=32'h0000_0401, HWInt=6'b000001, PC=30'h0C00, BD=0 -> IntReq=1 same cycle; next edge EPC=30'h0C00, EXL=1, ExcCode=0, IntReq=0.
REQ-033 Same with BD=1, PC=30'h0C01 -> EPC=30'h0C00, Cause[31]=1.
REQ-034 EXL=1, EXLClr pulse with HWInt still high -> EXL=0 next edge, IntReq=1 the cycle after.
REQ-035 CP0_EXC_EN defined, SR=0, ExcCode=12 -> IntReq=1, Cause read 32'h0000_0030; undefined -> IntReq=0.
REQ-036 WE=1 A2=14 DIn=32'h0000_3008 with IntReq=1 same edge -> EPC holds captured PC, not 3008; A1=15 -> PRID_VAL.
REQ-037 Assert reset between edges with EXL=1 -> SR, Cause, EPC read 0 before next edge.
